uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : Asynchronous serial receiver. Oversamples RX_IN with the system
//            clock, detects the start edge, samples each bit mid-period, and
//            delivers the data word with parity and framing status.
// Ports    : CLK      - system clock, all state on the rising edge
//            RST_N    - asynchronous active-low reset
//            RX_EN    - receiver enable; low aborts and holds in IDLE
//            RX_IN    - serial line, idle high (asynchronous)
//            RX_OUT   - last received data word (DATA_W bits)
//            DONE     - one-cycle pulse when a frame completes
//            BUSY     - high while a frame is in progress
//            PAR_ERR  - parity mismatch on the last frame (0 when PARITY=0)
//            FRM_ERR  - a stop bit was sampled low on the last frame
// Options  : UART_RX_MAJORITY_EN - when defined, every bit decision is a
//            2-of-3 vote over three neighbouring mid-bit samples.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLK_F     = 50000000,
    parameter int UART_B    = 115200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RX_EN,
    input  logic              RX_IN,
    output logic [DATA_W-1:0] RX_OUT,
    output logic              DONE,
    output logic              BUSY,
    output logic              PAR_ERR,
    output logic              FRM_ERR
);

    localparam int c_B_CNT = CLK_F / UART_B;
    localparam int c_HALF  = c_B_CNT / 2;
    localparam int c_CNT_W = $clog2(c_B_CNT);
    localparam int c_BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par_bit;
    logic                r_frm_acc;
    logic [DATA_W-1:0]   r_rx_out;
    logic                r_done;
    logic                r_par_err;
    logic                r_frm_err;

    logic                w_bit;
    logic                w_tick;
    logic                w_start_edge;
    logic                w_cnt_clr;
    logic                w_done;
    logic                w_par_err;

    // ------------------------------------------------------------------------
    // Line synchroniser. r_prev is the previous synchronised value, used for
    // falling-edge detection; because it must see a 1 before an edge counts,
    // a line stuck low (break) can never start a new frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // ------------------------------------------------------------------------
    // Bit value. The decision is always taken at count HALF-1. In voting mode
    // r_prev holds the sample from count HALF-2 and r_sync1 already holds the
    // value r_sync2 will present at count HALF, so the three votes cover
    // HALF-2..HALF without delaying the decision.
    // ------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
    assign w_bit = (r_prev & r_sync2) | (r_prev & r_sync1) | (r_sync2 & r_sync1);
`else
    assign w_bit = r_sync2;
`endif

    assign w_tick       = (r_cnt == c_CNT_W'(c_HALF - 1));
    assign w_start_edge = RX_EN & r_prev & ~r_sync2;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                // A high line at the start-bit centre is a glitch, not a frame.
                if (w_tick) begin
                    w_state_nxt = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit_cnt == c_BIT_W'(DATA_W - 1))) begin
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && (r_bit_cnt == c_BIT_W'(STOP_BITS - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Disable overrides everything: abort silently, outputs untouched.
        if (!RX_EN) begin
            w_state_nxt = S_IDLE;
            w_cnt_clr   = 1'b0;
            w_done      = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Baud counter: free-runs modulo B_CNT for the whole frame so that every
    // bit after the start check is sampled exactly B_CNT clocks later.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || (r_state == S_IDLE)) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_W'(c_B_CNT - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Bit index within the current DATA or STOP phase; zeroed on any change
    // of state so each phase counts from 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_bit_cnt <= '0;
        end else if (w_tick && ((r_state == S_DATA) || (r_state == S_STOP))) begin
            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Parity check over data plus received parity bit
    // ------------------------------------------------------------------------
    always_comb begin
        w_par_err = 1'b0;
        if (PARITY == 1) begin
            w_par_err = ^{r_shift, r_par_bit};
        end else if (PARITY == 2) begin
            w_par_err = ~^{r_shift, r_par_bit};
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: shift register, per-frame status and delivered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_frm_acc <= 1'b0;
            r_rx_out  <= '0;
            r_done    <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_cnt_clr) begin
                r_frm_acc <= 1'b0;
            end
            if (w_tick && (r_state == S_DATA)) begin
                // LSB arrives first, so shift right and insert at the top.
                r_shift <= {w_bit, r_shift[DATA_W-1:1]};
            end
            if (w_tick && (r_state == S_PAR)) begin
                r_par_bit <= w_bit;
            end
            if (w_tick && (r_state == S_STOP) && !w_bit) begin
                r_frm_acc <= 1'b1;
            end
            if (w_done) begin
                r_rx_out  <= r_shift;
                r_par_err <= w_par_err;
                r_frm_err <= r_frm_acc | ~w_bit;
            end
        end
    end

    assign RX_OUT  = r_rx_out;
    assign DONE    = r_done;
    assign BUSY    = (r_state != S_IDLE);
    assign PAR_ERR = r_par_err;
    assign FRM_ERR = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core. Two receivers share the
//            clock and reset: one 8N1 and one 8E1 (B_CNT = 16 for both).
//            Frames are serialised by the bench; the expected word and flags
//            are queued when a frame is sent and compared when DONE pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CLK_F = 1600;
    localparam int UART_B = 100;
    localparam int BIT_CLKS = CLK_F / UART_B;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_en;
    logic       rx0;
    logic       rx1;
    logic [7:0] rx_out0;
    logic [7:0] rx_out1;
    logic       done0, busy0, pe0, fe0;
    logic       done1, busy1, pe1, fe1;
    logic       done0_d, done1_d;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last0;

    uart_rx_core #(
        .CLK_F(CLK_F), .UART_B(UART_B), .DATA_W(8), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .CLK(clk), .RST_N(rst_n), .RX_EN(rx_en), .RX_IN(rx0),
        .RX_OUT(rx_out0), .DONE(done0), .BUSY(busy0),
        .PAR_ERR(pe0), .FRM_ERR(fe0)
    );

    uart_rx_core #(
        .CLK_F(CLK_F), .UART_B(UART_B), .DATA_W(8), .PARITY(1), .STOP_BITS(1)
    ) dut1 (
        .CLK(clk), .RST_N(rst_n), .RX_EN(rx_en), .RX_IN(rx1),
        .RX_OUT(rx_out1), .DONE(done1), .BUSY(busy1),
        .PAR_ERR(pe1), .FRM_ERR(fe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare on the falling edge whenever a receiver pulses DONE.
    always @(negedge clk) begin
        if (done0) begin
            chk("done0_expected", 32'(q0.size() > 0), 32'd1);
            chk("done0_one_cycle", 32'(done0_d), 32'd0);
            chk("busy0_after_done", 32'(busy0), 32'd0);
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("rx_out0", 32'(rx_out0), 32'(e.d));
                chk("par_err0", 32'(pe0), 32'(e.pe));
                chk("frm_err0", 32'(fe0), 32'(e.fe));
            end
        end
        if (done1) begin
            chk("done1_expected", 32'(q1.size() > 0), 32'd1);
            chk("done1_one_cycle", 32'(done1_d), 32'd0);
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("rx_out1", 32'(rx_out1), 32'(e.d));
                chk("par_err1", 32'(pe1), 32'(e.pe));
                chk("frm_err1", 32'(fe1), 32'(e.fe));
            end
        end
        done0_d = done0;
        done1_d = done1;
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Serialise one frame; parity bit only on the parity receiver.
    task automatic send(input int which, input logic [7:0] d, input logic pbit, input logic stopv);
        exp_t e;
        e.d  = d;
        e.pe = (which == 1) ? ((^d) ^ pbit) : 1'b0;
        e.fe = ~stopv;
        if (which == 0) begin
            q0.push_back(e);
            last0 = d;
        end else begin
            q1.push_back(e);
        end
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, pbit);
        drive_bit(which, stopv);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy0(input logic lvl, input int limit, input string tag);
        int k = 0;
        while (busy0 !== lvl && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy0), 32'(lvl));
    endtask

    initial begin
        rst_n = 1'b0;
        rx_en = 1'b1;
        rx0   = 1'b1;
        rx1   = 1'b1;
        done0_d = 1'b0;
        done1_d = 1'b0;
        last0 = 8'h00;
        idle(3);
        chk("reset_rx_out", 32'(rx_out0), 32'h0);
        chk("reset_done", 32'(done0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        chk("reset_par_err", 32'(pe0), 32'h0);
        chk("reset_frm_err", 32'(fe0), 32'h0);
        rst_n = 1'b1;
        idle(BIT_CLKS);

        // Basic 8N1 frame.
        send(0, 8'hA5, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("a5_consumed", 32'(q0.size()), 32'd0);

        // Even parity: bad parity bit, then good one.
        send(1, 8'h03, 1'b1, 1'b1);
        idle(BIT_CLKS);
        send(1, 8'h03, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("par_consumed", 32'(q1.size()), 32'd0);
        chk("par_err_holds", 32'(pe1), 32'd0);

        // Framing error, then a clean frame clears it.
        send(0, 8'h5A, 1'b0, 1'b0);
        rx0 = 1'b1;
        idle(BIT_CLKS);
        chk("frm_err_holds", 32'(fe0), 32'd1);
        send(0, 8'h11, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("frm_consumed", 32'(q0.size()), 32'd0);

        // Short glitch: false start, no DONE, data untouched.
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        wait_busy0(1'b1, 6, "glitch_busy_high");
        wait_busy0(1'b0, 20, "glitch_busy_low");
        idle(BIT_CLKS);
        chk("glitch_rx_out", 32'(rx_out0), 32'(last0));

        // Receiver disabled during bit 3 of 0xFF.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rx0 = 1'b1;
        idle(BIT_CLKS / 2);
        chk("abort_busy_before", 32'(busy0), 32'd1);
        rx_en = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 32'(busy0), 32'd0);
        idle(6 * BIT_CLKS);
        rx_en = 1'b1;
        idle(BIT_CLKS);
        chk("abort_rx_out", 32'(rx_out0), 32'(last0));
        send(0, 8'h3C, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("abort_next_consumed", 32'(q0.size()), 32'd0);

        // Break: line low through the stop bit and beyond.
        send(0, 8'h00, 1'b0, 1'b0);
        idle(3 * BIT_CLKS);
        chk("break_not_busy", 32'(busy0), 32'd0);
        rx0 = 1'b1;
        idle(BIT_CLKS);
        send(0, 8'h7E, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("break_next_consumed", 32'(q0.size()), 32'd0);

        // Reset mid-frame: outputs clear immediately, partial frame dropped.
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_out", 32'(rx_out0), 32'h0);
        chk("midrst_busy", 32'(busy0), 32'h0);
        chk("midrst_done", 32'(done0), 32'h0);
        chk("midrst_frm_err", 32'(fe0), 32'h0);
        chk("midrst_par_err", 32'(pe0), 32'h0);
        rx0 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(BIT_CLKS);
        send(0, 8'h01, 1'b0, 1'b1);
        send(0, 8'h80, 1'b0, 1'b1);
        idle(BIT_CLKS);
        chk("b2b_consumed", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
